// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared constants, types and helpers for the NN datapath blocks.
//               Provides the accumulator and shift-amount widths, the
//               convolution output-size function and signed saturation.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  localparam int ACC_W   = 32;
  localparam int SHIFT_W = 5;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic        [SHIFT_W-1:0] shift_t;

  // Number of valid window positions along one axis of a pre-padded frame.
  function automatic int out_size(input int in_size, input int k,
                                  input int stride, input int dilation);
    return (in_size - dilation * (k - 1) - 1) / stride + 1;
  endfunction

  // Clamp an accumulator value into the signed n-bit range. The result keeps
  // the accumulator width; callers take the low n bits.
  function automatic acc_t sat_signed(input acc_t x, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] xe;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    xe = 64'(x);
    if (xe > hi) begin
      return ACC_W'(hi);
    end
    if (xe < lo) begin
      return ACC_W'(lo);
    end
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dconv_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : dconv_linebuf
// Description : Line buffers plus window column registers for the depthwise
//               convolution. Tracks the raster position of incoming pixels
//               and presents the full dilated KxK window (including the pixel
//               arriving this cycle) together with window-valid / last flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dconv_linebuf
  import nn_pkg::*;
#(
  parameter int N        = 16,
  parameter int CH       = 3,
  parameter int SIZE     = 6,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int DILATION = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_vld,
  input  logic [CH*N-1:0]       pix_din,
  output logic [CH*K*K*N-1:0]   win_dout,
  output logic                  win_vld,
  output logic                  win_end
);

  localparam int CN   = CH * N;
  localparam int SPAN = DILATION * (K - 1);
  localparam int LB_N = (SPAN > 0) ? SPAN : 1;
  localparam int OUT  = out_size(SIZE, K, STRIDE, DILATION);
  localparam int LAST = SPAN + STRIDE * (OUT - 1);
  localparam int CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  // Position counters and stride phases; a phase of 0 marks a window origin.
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [PW-1:0] cph_q, cph_d, rph_q, rph_d;

  // lb_q[k][c] holds the pixel at column c, k+1 rows above the current row.
  logic [CN-1:0]   lb_q [LB_N][SIZE];
  // cr_q[e] holds the K-tall column vector captured e+1 pixels ago.
  logic [K*CN-1:0] cr_q [LB_N];
  // Column vector at the current column, row 0 of the window at the bottom.
  logic [K*CN-1:0] col_pk;

  // Advance raster position and stride phases on each accepted pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (pix_vld) begin
      if (col_q == CW'(SIZE - 1)) begin
        col_d = '0;
        cph_d = '0;
        if (row_q == CW'(SIZE - 1)) begin
          row_d = '0;
          rph_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          if (row_q >= CW'(SPAN)) begin
            rph_d = (rph_q == PW'(STRIDE - 1)) ? '0 : rph_q + 1'b1;
          end
        end
      end else begin
        col_d = col_q + 1'b1;
        if (col_q >= CW'(SPAN)) begin
          cph_d = (cph_q == PW'(STRIDE - 1)) ? '0 : cph_q + 1'b1;
        end
      end
    end
  end

  // Position state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_q <= '0;
      row_q <= '0;
      cph_q <= '0;
      rph_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cph_q <= cph_d;
      rph_q <= rph_d;
    end
  end

  // Line-buffer storage: contents survive reset, only positions restart.
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      lb_q[0][col_q] <= pix_din;
      for (int k = 1; k < LB_N; k++) begin
        lb_q[k][col_q] <= lb_q[k-1][col_q];
      end
    end
  end

  // Window column shift register, advanced once per accepted pixel.
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      cr_q[0] <= col_pk;
      for (int e = 1; e < LB_N; e++) begin
        cr_q[e] <= cr_q[e-1];
      end
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_colvec
    if (i == K - 1) begin : g_cur
      assign col_pk[i*CN +: CN] = pix_din;
    end else begin : g_lb
      assign col_pk[i*CN +: CN] = lb_q[DILATION*(K-1-i)-1][col_q];
    end
  end

  // Scatter window taps into the channel-major / tap-minor output layout.
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      logic [K*CN-1:0] col_sel;
      if (DILATION * (K - 1 - j) == 0) begin : g_cur
        assign col_sel = col_pk;
      end else begin : g_reg
        assign col_sel = cr_q[DILATION*(K-1-j)-1];
      end
      for (genvar c = 0; c < CH; c++) begin : g_ch
        assign win_dout[(c*K*K + i*K + j)*N +: N] = col_sel[i*CN + c*N +: N];
      end
    end
  end

  assign win_vld = pix_vld && (row_q >= CW'(SPAN)) && (col_q >= CW'(SPAN)) &&
                   (rph_q == '0) && (cph_q == '0);
  assign win_end = win_vld && (row_q == CW'(LAST)) && (col_q == CW'(LAST));

endmodule
`default_nettype wire

// File: rtl/dconv.sv
`default_nettype none
// ============================================================================
// Module      : dconv
// Description : Depthwise 2-D convolution over a pre-padded square frame,
//               all channels in parallel. Two-stage pipeline: register tap
//               products, then sum + bias, arithmetic shift and saturation.
//               Build option DCONV_RELU_EN clamps negative results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dconv
  import nn_pkg::*;
#(
  parameter int N             = 16,
  parameter int INPUT_CHANNEL = 3,
  parameter int INPUT_SIZE    = 6,
  parameter int KERNEL_SIZE   = 3,
  parameter int STRIDE        = 1,
  parameter int PADDING       = 0,   // frames arrive pre-padded; not used
  parameter int DILATION      = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           input_vld,
  input  logic [INPUT_CHANNEL*N-1:0]                     input_din,
  input  logic [INPUT_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*N-1:0] weight_din,
  input  logic [INPUT_CHANNEL*ACC_W-1:0]                 bias_din,
  input  logic [INPUT_CHANNEL*SHIFT_W-1:0]               shift_din,
  output logic [INPUT_CHANNEL*N-1:0]                     conv_dout,
  output logic                                           conv_dout_vld,
  output logic                                           conv_dout_end
);

  localparam int CH = INPUT_CHANNEL;
  localparam int K  = KERNEL_SIZE;
  localparam int KK = K * K;

  typedef logic signed [2*N-1:0] prod_t;
  typedef logic signed [N-1:0]   data_t;

  logic [CH*KK*N-1:0] win;
  logic               win_vld;
  logic               win_end;

  prod_t prod_q [CH][KK];
  prod_t prod_d [CH][KK];
  logic  vld1_q, vld1_d, end1_q, end1_d;

  logic [CH*N-1:0] conv_dout_q, conv_dout_d;
  logic            vld_q, vld_d, end_q, end_d;

  dconv_linebuf #(
    .N        (N),
    .CH       (CH),
    .SIZE     (INPUT_SIZE),
    .K        (K),
    .STRIDE   (STRIDE),
    .DILATION (DILATION)
  ) u_linebuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_vld  (input_vld),
    .pix_din  (input_din),
    .win_dout (win),
    .win_vld  (win_vld),
    .win_end  (win_end)
  );

  // Stage 1: full-width signed product of every tap on every channel.
  always_comb begin
    vld1_d = win_vld;
    end1_d = win_end;
    for (int c = 0; c < CH; c++) begin
      for (int t = 0; t < KK; t++) begin
        prod_d[c][t] = prod_t'(data_t'(win[(c*KK+t)*N +: N])) *
                       prod_t'(data_t'(weight_din[(c*KK+t)*N +: N]));
      end
    end
  end

  // Stage 1 valid/end flags.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld1_q <= 1'b0;
      end1_q <= 1'b0;
    end else begin
      vld1_q <= vld1_d;
      end1_q <= end1_d;
    end
  end

  // Stage 1 product registers; qualified by vld1_q so no reset is needed.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  // Stage 2: accumulate with bias, shift, saturate; hold output when idle.
  always_comb begin
    acc_t  acc;
    acc_t  sh;
    data_t res;
    conv_dout_d = conv_dout_q;
    vld_d       = vld1_q;
    end_d       = end1_q;
    for (int c = 0; c < CH; c++) begin
      acc = acc_t'(bias_din[c*ACC_W +: ACC_W]);
      for (int t = 0; t < KK; t++) begin
        acc = acc + acc_t'(prod_q[c][t]);
      end
      sh  = acc >>> shift_t'(shift_din[c*SHIFT_W +: SHIFT_W]);
      res = data_t'(sat_signed(sh, N));
`ifdef DCONV_RELU_EN
      if (res[N-1]) begin
        res = '0;
      end
`endif
      if (vld1_q) begin
        conv_dout_d[c*N +: N] = res;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      conv_dout_q <= '0;
      vld_q       <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      conv_dout_q <= conv_dout_d;
      vld_q       <= vld_d;
      end_q       <= end_d;
    end
  end

  assign conv_dout     = conv_dout_q;
  assign conv_dout_vld = vld_q;
  assign conv_dout_end = end_q;

endmodule
`default_nettype wire

// File: tb/tb_dconv.sv
`default_nettype none
// ============================================================================
// Module      : tb_dconv
// Description : Directed self-checking bench for dconv (6x6 stride-1 instance
//               plus a 7x7 stride-2 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dconv;

  localparam int N  = 16;
  localparam int C  = 3;
  localparam int K  = 3;
  localparam int KK = K * K;
  localparam int CN = C * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               input_vld;
  logic [CN-1:0]      input_din;
  logic [C*KK*N-1:0]  weight_din;
  logic [C*32-1:0]    bias_din;
  logic [C*5-1:0]     shift_din;
  logic [CN-1:0]      conv_dout;
  logic               conv_dout_vld;
  logic               conv_dout_end;

  logic               s2_vld;
  logic [CN-1:0]      s2_din;
  logic [CN-1:0]      s2_dout;
  logic               s2_dout_vld;
  logic               s2_dout_end;

  dconv #(.N(N), .INPUT_CHANNEL(C), .INPUT_SIZE(6), .KERNEL_SIZE(K),
          .STRIDE(1), .PADDING(0), .DILATION(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .input_vld(input_vld), .input_din(input_din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
    .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld),
    .conv_dout_end(conv_dout_end)
  );

  dconv #(.N(N), .INPUT_CHANNEL(C), .INPUT_SIZE(7), .KERNEL_SIZE(K),
          .STRIDE(2), .PADDING(0), .DILATION(1)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .input_vld(s2_vld), .input_din(s2_din),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
    .conv_dout(s2_dout), .conv_dout_vld(s2_dout_vld),
    .conv_dout_end(s2_dout_end)
  );

  int tests;
  int fails;
  int cyc = 0;
  int in22_cyc;

  logic [CN-1:0] got_q [$];
  int            got_cyc [$];
  bit            got_end [$];
  logic [CN-1:0] s2_got [$];
  bit            s2_end [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid output of both instances away from the rising edge.
  always @(negedge clk) begin
    if (conv_dout_vld) begin
      got_q.push_back(conv_dout);
      got_cyc.push_back(cyc);
      got_end.push_back(conv_dout_end);
    end
    if (s2_dout_vld) begin
      s2_got.push_back(s2_dout);
      s2_end.push_back(s2_dout_end);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: all ones, 1: ramp r*6+c (+40 per channel), 2: 0x7FFF, 3: 0x8000
  function automatic logic [CN-1:0] pix(input int mode, input int r, input int c);
    logic [CN-1:0] v;
    for (int ch = 0; ch < C; ch++) begin
      case (mode)
        0:       v[ch*N +: N] = 16'd1;
        1:       v[ch*N +: N] = 16'(r * 6 + c + 40 * ch);
        2:       v[ch*N +: N] = 16'h7FFF;
        default: v[ch*N +: N] = 16'h8000;
      endcase
    end
    return v;
  endfunction

  function automatic logic [CN-1:0] exp_out(input int mode, input int i, input int j);
    logic [CN-1:0] v;
    for (int ch = 0; ch < C; ch++) begin
      case (mode)
        0:       v[ch*N +: N] = 16'd9;
        1:       v[ch*N +: N] = 16'((i + 1) * 6 + (j + 1) + 40 * ch);
        2:       v[ch*N +: N] = 16'h7FFF;
`ifdef DCONV_RELU_EN
        default: v[ch*N +: N] = 16'h0000;
`else
        default: v[ch*N +: N] = 16'h8000;
`endif
      endcase
    end
    return v;
  endfunction

  task automatic set_weights(input logic [15:0] w_other, input logic [15:0] w_centre,
                             input logic [31:0] b, input logic [4:0] s);
    for (int ch = 0; ch < C; ch++) begin
      for (int t = 0; t < KK; t++) begin
        weight_din[(ch*KK+t)*N +: N] = (t == 4) ? w_centre : w_other;
      end
      bias_din[ch*32 +: 32] = b;
      shift_din[ch*5 +: 5]  = s;
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic drive_frame(input int mode, input bit bubbles, input int npix);
    for (int idx = 0; idx < npix; idx++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 3)) begin
          input_vld = 1'b0;
          @(negedge clk);
        end
      end
      input_vld = 1'b1;
      input_din = pix(mode, idx / 6, idx % 6);
      if (idx == 14) in22_cyc = cyc;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    input_vld = 1'b0;
    s2_vld    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_caps();
    @(posedge clk);
    got_q.delete();
    got_cyc.delete();
    got_end.delete();
    s2_got.delete();
    s2_end.delete();
    @(negedge clk);
  endtask

  task automatic chk_frame(input string tag, input int mode, input int nframes);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(16 * nframes));
    for (int k = 0; k < got_q.size(); k++) begin
      int f;
      f = k % 16;
      chk($sformatf("%s_val%0d", tag, k), got_q[k], exp_out(mode, f / 4, f % 4));
      chk($sformatf("%s_end%0d", tag, k), 64'(got_end[k]), 64'(f == 15));
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    in22_cyc   = 0;
    rst_n      = 1'b1;
    input_vld  = 1'b0;
    input_din  = '0;
    s2_vld     = 1'b0;
    s2_din     = '0;
    weight_din = '0;
    bias_din   = '0;
    shift_din  = '0;
    set_weights(16'd1, 16'd1, 32'd0, 5'd0);
    repeat (3) @(negedge clk);

    chk("rst_dout", 64'(conv_dout), 64'd0);
    chk("rst_vld",  64'(conv_dout_vld), 64'd0);
    chk("rst_end",  64'(conv_dout_end), 64'd0);
    chk("rst_s2_vld", 64'(s2_dout_vld), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // All ones: 16 outputs of 9, first 2 cycles after pixel (2,2).
    clear_caps();
    drive_frame(0, 1'b0, 36);
    idle(6);
    chk_frame("ones", 0, 1);
    chk("ones_latency", 64'((got_cyc.size() > 0) ? got_cyc[0] - in22_cyc : -1), 64'd2);
    chk("ones_hold", 64'(conv_dout), 64'(exp_out(0, 3, 3)));
    chk("ones_hold_vld", 64'(conv_dout_vld), 64'd0);

    // Centre-tap ramp, two frames back to back.
    set_weights(16'd0, 16'd256, 32'd5, 5'd8);
    clear_caps();
    drive_frame(1, 1'b0, 36);
    drive_frame(1, 1'b0, 36);
    idle(6);
    chk_frame("ramp2", 1, 2);

    // Same ramp with random input_vld bubbles.
    clear_caps();
    drive_frame(1, 1'b1, 36);
    idle(6);
    chk_frame("bubble", 1, 1);

    // Positive and negative saturation.
    set_weights(16'h7FFF, 16'h7FFF, 32'd0, 5'd0);
    clear_caps();
    drive_frame(2, 1'b0, 36);
    idle(6);
    chk_frame("satpos", 2, 1);
    clear_caps();
    drive_frame(3, 1'b0, 36);
    idle(6);
    chk_frame("satneg", 3, 1);

    // Reset after 20 pixels, then a full ramp frame.
    set_weights(16'd0, 16'd256, 32'd5, 5'd8);
    drive_frame(1, 1'b0, 20);
    input_vld = 1'b0;
    rst_n     = 1'b1;
    clear_caps();
    rst_n = 1'b0;
    drive_frame(1, 1'b0, 36);
    idle(6);
    chk_frame("midrst", 1, 1);

    // Stride 2 on a 7x7 all-ones frame: 9 outputs of 9.
    set_weights(16'd1, 16'd1, 32'd0, 5'd0);
    clear_caps();
    for (int idx = 0; idx < 49; idx++) begin
      s2_vld = 1'b1;
      s2_din = pix(0, 0, 0);
      @(negedge clk);
    end
    idle(6);
    chk("s2_count", 64'(s2_got.size()), 64'd9);
    for (int k = 0; k < s2_got.size(); k++) begin
      chk($sformatf("s2_val%0d", k), s2_got[k], exp_out(0, 0, 0));
      chk($sformatf("s2_end%0d", k), 64'(s2_end[k]), 64'(k == 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard ceiling so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dconv.md
DCONV -- requirements
Module: dconv

Interface
REQ-001 SHALL have parameter N, default 16: signed data/weight width.
REQ-002 SHALL have parameter INPUT_CHANNEL, default 3: channel count; all channels are processed in parallel.
REQ-003 SHALL have parameter INPUT_SIZE, default 6: square frame side, padding already included.
REQ-004 SHALL have parameter KERNEL_SIZE, default 3 (K): square kernel side.
REQ-005 SHALL have parameter STRIDE, default 1: window step in both axes.
REQ-006 SHALL have parameter PADDING, default 0: informational only, because the input arrives pre-padded.
REQ-007 SHALL have parameter DILATION, default 1: spacing between kernel taps.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port input_vld, input, 1 bit: input_din holds one pixel this cycle.
REQ-011 SHALL have port input_din, input, INPUT_CHANNEL*N bits: channel c at [c*N +: N], signed.
REQ-012 SHALL have port weight_din, input, INPUT_CHANNEL*K*K*N bits: channel c tap t=row*K+col at [(c*K*K+t)*N +: N], signed.
REQ-013 SHALL have port bias_din, input, INPUT_CHANNEL*32 bits: channel c at [c*32 +: 32], signed.
REQ-014 SHALL have port shift_din, input, INPUT_CHANNEL*5 bits: channel c right-shift amount at [c*5 +: 5], unsigned.
REQ-015 SHALL have port conv_dout, output, INPUT_CHANNEL*N bits: channel c result at [c*N +: N].
REQ-016 SHALL have port conv_dout_vld, output, 1 bit: conv_dout is valid this cycle.
REQ-017 SHALL have port conv_dout_end, output, 1 bit: marks the last output of the frame.

Function
REQ-018 SHALL accept pixels in raster order, one per input_vld cycle, INPUT_SIZE*INPUT_SIZE pixels per frame; no backpressure; input_vld gaps of any length SHALL be allowed.
REQ-019 SHALL produce OUT=(INPUT_SIZE-DILATION*(K-1)-1)/STRIDE+1 outputs per axis, in raster order.
REQ-020 Per channel, SHALL compute acc = sum over taps of x*w (full 2N-bit products) + bias, in a 32-bit signed accumulator.
REQ-021 SHALL compute res = acc >>> shift, an arithmetic truncating shift.
REQ-022 SHALL saturate res to the signed N-bit range: 0x7FFF / 0x8000 for N=16.
REQ-023 SHALL assert conv_dout_vld exactly 2 clk cycles after the input_vld cycle carrying a window's bottom-right pixel (pipeline: register products, then sum/bias/shift/saturate).
REQ-024 SHALL assert conv_dout_end together with conv_dout_vld on the OUT*OUT-th output only.
REQ-025 SHALL wrap the row/column counters to 0 after the last pixel; back-to-back frames SHALL be supported with no idle cycle.
REQ-026 SHALL hold conv_dout at its last value when conv_dout_vld is low.
REQ-027 SHALL latch weights, bias and shift combinationally from the ports; the ports SHALL be held stable for the whole frame.

Reset
REQ-028 When rst_n is high, SHALL clear conv_dout, conv_dout_vld, conv_dout_end, all counters and pipeline valid bits to 0 on the next edge.
REQ-029 A reset mid-frame SHALL discard in-flight results; the next input_vld pixel SHALL be treated as pixel (0,0).
REQ-030 SHALL NOT reset line-buffer contents.

Configuration
REQ-031 When macro DCONV_RELU_EN is defined, SHALL clamp negative saturated results to 0; when it is undefined, SHALL output the signed saturated result unchanged.

Structure
REQ-032 SHALL take ACC_W=32, SHIFT_W=5, an output-size function and a signed-saturate function from shared package nn_pkg.
REQ-033 SHALL contain one sub-module, dconv_linebuf: (K-1)*DILATION line buffers of depth INPUT_SIZE plus the KxK window registers, outputting the window and window-valid.

Verification
REQ-034 All weights 0x0001, bias 0, shift 0, all inputs 1 on a 6x6 frame -> 16 outputs, each 9 on every channel; the first is 2 cycles after pixel (2,2); end is asserted with the 16th.
REQ-035 Centre weight 256, others 0, bias 5, shift 8, input ramp p=r*6+c -> output (i,j) = (i+1)*6+(j+1).
REQ-036 All inputs and weights 0x7FFF, shift 0 -> 0x7FFF; inputs 0x8000 with weights 0x7FFF -> 0x8000, or 0 with DCONV_RELU_EN.
REQ-037 Vector of REQ-035 with random input_vld bubbles -> identical 16 values, one end pulse.
REQ-038 Reset after 20 pixels, then a full frame -> exactly 16 correct outputs, none stale.
REQ-039 STRIDE=2, INPUT_SIZE=7, all-ones stimulus -> 9 outputs of value 9, end on the 9th.
